// File: rtl/oled_line_arbiter.sv
// oled_line_arbiter: round-robin sharing of the OLED_ctrl line-write/update port between NREQ requesters
module oled_line_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_row,
  input  logic [128*NREQ-1:0]   req_text,
  input  logic [NREQ-1:0]       req_update,
  output logic [NREQ-1:0]       req_done,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  write_start,
  output logic [8:0]            write_base_addr,
  output logic [7:0]            write_ascii_data,
  input  logic                  write_ready,
  output logic                  update_start,
  output logic                  update_clear,
  input  logic                  update_ready
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, WR_START, WR_GAP, WR_WAIT, UPD_START, UPD_GAP, UPD_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [3:0] col, col_n;
  logic [IW-1:0] last, last_n, owner, owner_n, sel;
  logic [1:0] row, row_n;
  logic [127:0] text, text_n;
  logic upd, upd_n;
  logic [NREQ-1:0] done_n, grant_n;
  logic write_start_n, update_start_n;
  logic [8:0] addr_n;
  logic [7:0] data_n;
  assign update_clear = 1'b0;
  // first pending requester searching upward from the one after the last owner
  always_comb begin
    sel = last;
    for (int k = NREQ; k >= 1; k--)
      if (req_valid[(int'(last) + k) % NREQ]) sel = IW'((int'(last) + k) % NREQ);
  end
  // next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_n = state;
    col_n = col;
    last_n = last;
    owner_n = owner;
    row_n = row;
    text_n = text;
    upd_n = upd;
    grant_n = grant;
    write_start_n = 1'b0;
    update_start_n = 1'b0;
    addr_n = write_base_addr;
    data_n = write_ascii_data;
    case (state)
      IDLE: if (|req_valid) begin
        owner_n = sel;
        row_n = req_row[2*sel +: 2];
        text_n = req_text[128*sel +: 128];
        upd_n = req_update[sel];
        grant_n = NREQ'(1) << sel;
        col_n = 4'd0;
        state_n = WR_START;
      end
      WR_START: if (write_ready) begin
        write_start_n = 1'b1;
        addr_n = {row, col, 3'b000};
        data_n = text[{~col, 3'b000} +: 8];
        state_n = WR_GAP;
      end
      WR_GAP: state_n = WR_WAIT;
      WR_WAIT: if (write_ready) begin
        state_n = (col == 4'd15) ? (upd ? UPD_START : DONE) : WR_START;
        col_n = (col == 4'd15) ? col : col + 4'd1;
      end
      UPD_START: if (update_ready) begin
        update_start_n = 1'b1;
        state_n = UPD_GAP;
      end
      UPD_GAP: state_n = UPD_WAIT;
      UPD_WAIT: if (update_ready) state_n = DONE;
      DONE: begin
        last_n = owner;
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    done_n = (state_n == DONE) ? grant : '0;
  end
  // state, job context and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      col <= '0;
      last <= IW'(NREQ - 1);
      owner <= '0;
      row <= '0;
      text <= '0;
      upd <= 1'b0;
      grant <= '0;
      req_done <= '0;
      busy <= 1'b0;
      write_start <= 1'b0;
      update_start <= 1'b0;
      write_base_addr <= '0;
      write_ascii_data <= '0;
    end else begin
      state <= state_n;
      col <= col_n;
      last <= last_n;
      owner <= owner_n;
      row <= row_n;
      text <= text_n;
      upd <= upd_n;
      grant <= grant_n;
      req_done <= done_n;
      busy <= (state_n != IDLE);
      write_start <= write_start_n;
      update_start <= update_start_n;
      write_base_addr <= addr_n;
      write_ascii_data <= data_n;
    end
  end
endmodule

// File: doc/oled_line_arbiter.md
# oled_line_arbiter

Shares the single character-write/update port of `OLED_ctrl` between `NREQ` independent requesters. Each requester submits one 16-character text line for one of the four display rows. The block grants requesters round-robin and sequences the 16 per-character write handshakes, then an optional display update. It sits between application logic (status, menu, debug writers) and `OLED_ctrl`, replacing a hard-wired single sequencer.

## Interface
- `NREQ`, 2, number of requesters (2..4)
- `clk`  in  1  system clock
- `rstn`  in  1  reset; one clock; asynchronous, active-low
- `req_valid`  in  NREQ  requester i has a line pending
- `req_row`  in  2*NREQ  target row of requester i, bits [2i+1:2i]; 0 = top
- `req_text`  in  128*NREQ  16 ASCII chars of requester i, slice [128i+127:128i]; char 0 (leftmost) in the top byte of the slice
- `req_update`  in  NREQ  issue a display update after the line
- `req_done`  out  NREQ  one-cycle pulse when requester i's job completes
- `grant`  out  NREQ  one-hot owner of the current job; 0 when idle
- `busy`  out  1  high in every state except IDLE
- `write_start`  out  1  to `OLED_ctrl`, one-cycle pulse
- `write_base_addr`  out  9  {row[1:0], col[3:0], 3'b000}
- `write_ascii_data`  out  8  character for `write_base_addr`
- `write_ready`  in  1  from `OLED_ctrl`
- `update_start`  out  1  to `OLED_ctrl`, one-cycle pulse
- `update_clear`  out  1  tied 0
- `update_ready`  in  1  from `OLED_ctrl`

## Operation
- All outputs are registered. While `rstn` = 0, every output is 0, the state is IDLE, the column is 0, and the round-robin pointer `last` = NREQ-1, so requester 0 wins first.
- **IDLE**
  - If any `req_valid` bit is set, select the first set bit searching from `last+1` modulo NREQ.
  - Capture that requester's row, text and update flag into internal registers.
  - Set `grant`, set col = 0, go to WR_START.
- **WR_START**
  - Wait for `write_ready` = 1.
  - Then, for one cycle, drive `write_start` = 1, `write_base_addr` = {row, col, 000} and `write_ascii_data` = text byte col (byte 0 = bits [127:120]). Go to WR_GAP.
- **WR_GAP**
  - `write_start` = 0. Lasts one cycle, because `OLED_ctrl` drops ready the cycle after it accepts a start. Go to WR_WAIT.
- **WR_WAIT**
  - Advance when `write_ready` = 1.
  - If col = 15: go to UPD_START if the captured update flag is 1, otherwise go to DONE.
  - Otherwise: col += 1 and go to WR_START.
- **UPD_START / UPD_GAP / UPD_WAIT**
  - Same three-step handshake as the write states, using `update_start` and `update_ready`. Then go to DONE.
- **DONE**
  - Pulse `req_done[owner]` for one cycle, set `last` = owner, clear `grant`, go to IDLE.
- Data is captured at grant. Requester inputs may change after the grant cycle without affecting the job in progress.
- A requester must drop `req_valid` on the cycle after `req_done`. If it is still high when IDLE samples, it is served again as a new job, subject to round-robin order.
- Requests arriving while busy wait; no request is dropped and there is no queueing beyond the `req_valid` level.
- The column is 4 bits and the job terminates at 15; there is no wrap into the next row.

## Timing
- Grant latency: IDLE samples `req_valid`; `write_start` can be asserted at the earliest 1 cycle later (WR_START, with `write_ready` already high).
- Per character: at least 3 cycles (WR_START, WR_GAP, WR_WAIT) plus `OLED_ctrl` busy time.
- Job overhead: 1 cycle IDLE + 1 cycle DONE. Back-to-back jobs from different requesters need at least 2 idle cycles between the last write and the next grant.
- Simultaneous requests in the same cycle are resolved by round robin only.
- Reset asserted mid-job:
  - Outputs clear immediately and the job is abandoned; no `req_done` is issued.
  - `OLED_ctrl` completes any accepted operation on its own.
  - After release, WR_START gates on `write_ready`, so no start is issued into a busy controller.
- `write_ready` low at job start simply stalls in WR_START.

## Test plan
- Single request: requester 0, row 2, text "ABCDEFGHIJKLMNOP", update = 1, ctrl model ready after 5 cycles.
  - 16 write pulses with addr 0x100, 0x108 … 0x178 and data 0x41 … 0x50.
  - Then exactly 1 `update_start`, then a `req_done[0]` pulse.
- Simultaneous `req_valid` = 2'b11 after reset: requester 0 is served first, then requester 1 (its row/text on the addresses). If both stay asserted, grant order continues 0, 1, 0.
- Update flag 0, row 3: the last write goes to addr 0x1F8 and `req_done` follows without any `update_start`.
- Request 1 raised mid-job for requester 0:
  - Requester 0's 16 writes are uninterrupted.
  - Requester 1's `grant` rises only after `req_done[0]`.
  - `req_text` changed after the grant does not alter the emitted data.
- Reset at char 7:
  - `write_start`, `grant` and `busy` are all 0 within the reset.
  - No `req_done` is issued.
  - After release with `req_valid[0]` still high, the job restarts at col 0, addr {row, 0, 000}.
- `write_ready` held low for 100 cycles at WR_START: no `write_start` is issued until it rises; exactly one pulse per character.
